crypto_result_collector: RTL and testbench

// - Sink side of the crypto core result port. Captures each DATA_WIDTH result block pulsed on s2_valid.
// - Buffers blocks in a small FIFO and serialises them LSW-first onto a OUT_WIDTH valid/ready stream.
// - Marks packet boundaries with m_tlast and gives advisory backpressure (s2_ready) to the core issue logic.
// - The core does not stall on s2_ready, so a push that arrives when there is no room is dropped and flagged.

---
 rtl/crypto_pkg.sv | 18 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/crypto_result_collector.sv | 144 ++++++++++++++
 tb/tb_crypto_result_collector.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// rtl/crypto_pkg.sv - shared types and constants for the crypto result path
package crypto_pkg;

    localparam int CRYPTO_BLK_W = 128;
    localparam int CRYPTO_OUT_W = 32;
    localparam int BEATS        = CRYPTO_BLK_W / CRYPTO_OUT_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } collector_state_e;

    // Zero length is treated as a single-block packet.
    function automatic logic [15:0] pkt_len_of(input logic [15:0] cfg);
        return (cfg == 16'd0) ? 16'd1 : cfg;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers; pushes while full are ignored
module sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    // Fullness is judged on the registered pointers, so a same-edge pop never makes room.
    assign push_ok = push && !full && !clr;
    assign pop_ok  = pop && !empty && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/crypto_result_collector.sv
// rtl/crypto_result_collector.sv - buffers crypto result blocks and serialises them LSW-first onto a packet stream
module crypto_result_collector
    import crypto_pkg::*;
#(
    parameter int DATA_WIDTH = CRYPTO_BLK_W,
    parameter int OUT_WIDTH  = CRYPTO_OUT_W,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  s2_valid,
    input  logic [DATA_WIDTH-1:0] s2_data,
    output logic                  s2_ready,
    input  logic [LEN_W-1:0]      cfg_pkt_blocks,
    output logic                  m_tvalid,
    output logic [OUT_WIDTH-1:0]  m_tdata,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  overflow,
    output logic [LEN_W-1:0]      blk_count,
    output logic                  busy
);

    localparam int NBEATS = DATA_WIDTH / OUT_WIDTH;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);

    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [BW-1:0]    BEAT_ONE  = BW'(1);
    localparam logic [BW-1:0]    BEAT_LAST = BW'(NBEATS - 1);
    localparam logic [AW:0]      READY_MAX = (AW + 1)'(FIFO_DEPTH - 2);

    collector_state_e      state;
    logic [DATA_WIDTH-1:0] sr;
    logic [BW-1:0]         beat;
    logic [LEN_W-1:0]      pkt_len;
    logic [LEN_W-1:0]      blk_in_pkt;
    logic                  pkt_start;
    logic                  ready_en;
    logic                  overflow_q;
    logic [LEN_W-1:0]      blk_count_q;

    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [AW:0]           fifo_count;

    logic                  accept;
    logic                  blk_done;
    logic                  pkt_end;
    logic                  pop;
    logic                  next_is_start;
    logic [LEN_W-1:0]      cfg_len;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (s2_valid),
        .wdata (s2_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign accept        = (state == SEND) && m_tready;
    assign blk_done      = accept && (beat == BEAT_LAST);
    assign pkt_end       = blk_done && ((blk_in_pkt + LEN_ONE) == pkt_len);
    // A finishing block hands over to the next FIFO entry on the same edge, so streams have no bubble.
    assign pop           = !clr && !fifo_empty && ((state == IDLE) || blk_done);
    assign next_is_start = pkt_start || pkt_end;
    assign cfg_len       = (cfg_pkt_blocks == '0) ? LEN_ONE : cfg_pkt_blocks;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sr          <= '0;
            beat        <= '0;
            pkt_len     <= '0;
            blk_in_pkt  <= '0;
            pkt_start   <= 1'b1;
            ready_en    <= 1'b0;
            overflow_q  <= 1'b0;
            blk_count_q <= '0;
        end else if (clr) begin
            state       <= IDLE;
            sr          <= '0;
            beat        <= '0;
            pkt_len     <= '0;
            blk_in_pkt  <= '0;
            pkt_start   <= 1'b1;
            ready_en    <= 1'b1;
            overflow_q  <= 1'b0;
            blk_count_q <= '0;
        end else begin
            ready_en <= 1'b1;
            if (s2_valid && fifo_full) overflow_q <= 1'b1;

            if (accept) begin
                sr   <= sr >> OUT_WIDTH;
                beat <= beat + BEAT_ONE;
            end

            if (blk_done) begin
                blk_count_q <= blk_count_q + LEN_ONE;
                state       <= IDLE;
                if (pkt_end) begin
                    blk_in_pkt <= '0;
                    pkt_start  <= 1'b1;
                end else begin
                    blk_in_pkt <= blk_in_pkt + LEN_ONE;
                end
            end

            // Loading overrides the end-of-block updates above for the new block.
            if (pop) begin
                sr    <= fifo_rdata;
                beat  <= '0;
                state <= SEND;
                if (next_is_start) begin
                    pkt_len    <= cfg_len;
                    blk_in_pkt <= '0;
                    pkt_start  <= 1'b0;
                end
            end
        end
    end

    assign m_tvalid  = (state == SEND);
    assign m_tdata   = sr[OUT_WIDTH-1:0];
    assign m_tlast   = (state == SEND) && (beat == BEAT_LAST) && (blk_in_pkt == (pkt_len - LEN_ONE));
    assign s2_ready  = ready_en && (fifo_count <= READY_MAX);
    assign overflow  = overflow_q;
    assign blk_count = blk_count_q;
    assign busy      = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_crypto_result_collector.sv
// tb/tb_crypto_result_collector.sv - self-checking bench for crypto_result_collector
module tb_crypto_result_collector;

    localparam int LW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           clr = 1'b0;
    logic           s2_valid = 1'b0;
    logic [127:0]   s2_data = '0;
    logic           s2_ready;
    logic [LW-1:0]  cfg = 8'd1;
    logic           m_tvalid;
    logic [31:0]    m_tdata;
    logic           m_tlast;
    logic           m_tready = 1'b0;
    logic           overflow;
    logic [LW-1:0]  blk_count;
    logic           busy;

    crypto_result_collector #(
        .DATA_WIDTH (128),
        .OUT_WIDTH  (32),
        .FIFO_DEPTH (4),
        .LEN_W      (LW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (clr),
        .s2_valid       (s2_valid),
        .s2_data        (s2_data),
        .s2_ready       (s2_ready),
        .cfg_pkt_blocks (cfg),
        .m_tvalid       (m_tvalid),
        .m_tdata        (m_tdata),
        .m_tlast        (m_tlast),
        .m_tready       (m_tready),
        .overflow       (overflow),
        .blk_count      (blk_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference model: blocks in acceptance order, cut into beats and packets at observation time.
    logic [127:0] exp_q[$];
    int           beat_m, blk_m, len_m;
    logic [LW-1:0] count_m;
    int           beats_seen, cyc, first_cyc, last_cyc;
    bit           stall_prev;
    logic [31:0]  prev_data;
    logic         prev_last;

    task automatic model_reset();
        exp_q.delete();
        beat_m = 0; blk_m = 0; len_m = 1; count_m = '0; stall_prev = 0;
    endtask

    task automatic sb_beat();
        logic [127:0] blk;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got data %0h, required no beat", m_tdata);
            return;
        end
        blk = exp_q[0];
        if (beat_m == 0 && blk_m == 0) len_m = (cfg == 0) ? 1 : int'(cfg);
        check("beat_data", m_tdata, blk[beat_m*32 +: 32]);
        check("beat_last", m_tlast, (beat_m == 3) && (blk_m == len_m - 1));
        if (beats_seen == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats_seen++;
        beat_m++;
        if (beat_m == 4) begin
            beat_m = 0;
            void'(exp_q.pop_front());
            count_m++;
            blk_m++;
            if (blk_m == len_m) blk_m = 0;
        end
    endtask

    task automatic cycle(input logic v, input logic [127:0] d, input logic rdy, input logic drop);
        s2_valid = v; s2_data = d; m_tready = rdy;
        if (stall_prev) begin
            check("stall_valid", m_tvalid, 1'b1);
            check("stall_data", m_tdata, prev_data);
            check("stall_last", m_tlast, prev_last);
        end
        if (m_tvalid && rdy) sb_beat();
        stall_prev = m_tvalid && !rdy;
        prev_data = m_tdata;
        prev_last = m_tlast;
        if (v && !drop) exp_q.push_back(d);
        cyc++;
        @(posedge clk); #1;
        s2_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        check("drain_idle", busy, 1'b0);
        check("drain_queue_empty", exp_q.size(), 0);
        check("blk_count_model", blk_count, count_m);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct packed {
        logic [127:0]     data;
        logic [LW-1:0]    cfg;
        logic             last;
        logic [3:0][31:0] beats;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed, n;
        logic [127:0] d;
        model_reset();
        cyc = 0;

        vecs[0] = '{128'h33333333_22222222_11111111_00000000, 8'd1, 1'b1,
                    {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000}};
        vecs[1] = '{128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 8'd0, 1'b1,
                    {32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF}};
        vecs[2] = '{128'h80000000_00000001_00000000_FFFFFFFF, 8'd2, 1'b0,
                    {32'h80000000, 32'h00000001, 32'h00000000, 32'hFFFFFFFF}};
        vecs[3] = '{128'h0F0F0F0F_F0F0F0F0_AAAAAAAA_55555555, 8'd7, 1'b1,
                    {32'h0F0F0F0F, 32'hF0F0F0F0, 32'hAAAAAAAA, 32'h55555555}};
        vecs[4] = '{{128{1'b1}}, 8'd1, 1'b1,
                    {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}};

        #1 rst_n = 1'b0;
        #11;
        check("rst_s2_ready", s2_ready, 1'b0);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tdata", m_tdata, 32'h0);
        check("rst_m_tlast", m_tlast, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_blk_count", blk_count, 8'h0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", s2_ready, 1'b1);

        // Single blocks from the table: latency, beat order and tlast.
        for (int i = 0; i < 5; i++) begin
            cfg = vecs[i].cfg;
            cycle(1'b1, vecs[i].data, 1'b1, 1'b0);
            check("lat_n1_valid", m_tvalid, 1'b0);
            cycle(1'b0, '0, 1'b1, 1'b0);
            for (int b = 0; b < 4; b++) begin
                check("tbl_valid", m_tvalid, 1'b1);
                check("tbl_data", m_tdata, vecs[i].beats[b]);
                check("tbl_last", m_tlast, (b == 3) && vecs[i].last);
                cycle(1'b0, '0, 1'b1, 1'b0);
            end
            check("tbl_done_valid", m_tvalid, 1'b0);
            check("tbl_done_busy", busy, 1'b0);
        end
        check("tbl_blk_count", blk_count, 8'd5);

        // Packet of three, pulses four cycles apart: one contiguous 12-beat run.
        cfg = 8'd3;
        beats_seen = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, rnd128(), 1'b1, 1'b0);
            for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        end
        drain(50);
        check("pkt3_beats", beats_seen, 12);
        check("pkt3_contiguous", last_cyc - first_cyc, 11);

        // Backpressure: one block in the shift register, four in the FIFO, sixth dropped.
        cfg = 8'd1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, rnd128(), 1'b0, i == 5);
            check("bp_s2_ready", s2_ready, i < 3);
            check("bp_overflow", overflow, i == 5);
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        // Push on the same edge as a pop while full must still be dropped.
        cycle(1'b1, rnd128(), 1'b1, 1'b1);
        check("bp_overflow_sticky", overflow, 1'b1);
        drain(100);

        // Stall stability with m_tready toggling mid-block.
        beats_seen = 0;
        cycle(1'b1, 128'h44444444_33333333_22222222_11111111, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) cycle(1'b0, '0, (k % 4 == 0) || (k % 4 == 3), 1'b0);
        drain(50);
        check("stall_beats", beats_seen, 4);

        // Asynchronous reset during beat 2.
        d = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        cycle(1'b1, d, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("pre_reset_beat2", m_tdata, 32'hCCCCCCCC);
        rst_n = 1'b0;
        #1;
        check("arst_m_tvalid", m_tvalid, 1'b0);
        check("arst_m_tdata", m_tdata, 32'h0);
        check("arst_m_tlast", m_tlast, 1'b0);
        check("arst_s2_ready", s2_ready, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_blk_count", blk_count, 8'h0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1, 128'h13131313_12121212_11111111_10101010, 1'b1, 1'b0);
        drain(50);

        // Synchronous clear with blocks queued and overflow set; clear beats a same-cycle push.
        for (int i = 0; i < 6; i++) cycle(1'b1, rnd128(), 1'b0, i == 5);
        check("pre_clr_overflow", overflow, 1'b1);
        check("pre_clr_busy", busy, 1'b1);
        clr = 1'b1;
        cycle(1'b1, rnd128(), 1'b0, 1'b1);
        clr = 1'b0;
        model_reset();
        check("clr_busy", busy, 1'b0);
        check("clr_overflow", overflow, 1'b0);
        check("clr_m_tvalid", m_tvalid, 1'b0);
        check("clr_blk_count", blk_count, 8'h0);
        check("clr_s2_ready", s2_ready, 1'b1);

        // cfg 0 behaves as single-block packets; blk_count wraps.
        cfg = 8'd0;
        pushed = 0;
        n = 0;
        while (pushed < 255 && n < 5000) begin
            if (s2_ready) begin
                cycle(1'b1, rnd128(), 1'b1, 1'b0);
                pushed++;
            end else begin
                cycle(1'b0, '0, 1'b1, 1'b0);
            end
            n++;
        end
        check("wrap_pushed", pushed, 255);
        drain(100);
        check("wrap_before", blk_count, 8'hFF);
        cycle(1'b1, rnd128(), 1'b1, 1'b0);
        drain(50);
        check("wrap_after", blk_count, 8'h00);

        // Randomised traffic against the model.
        for (int r = 0; r < 3; r++) begin
            cfg = LW'($urandom_range(0, 4));
            for (int k = 0; k < 400; k++) begin
                cycle(s2_ready && ($urandom_range(0, 1) == 1), rnd128(),
                      $urandom_range(0, 3) != 0, 1'b0);
            end
            drain(200);
            check("rand_no_overflow", overflow, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
